// File: rtl/mcb_port_responder.sv
// Behavioural stand-in for one MCB user port: calibration delay, command/write/read FIFOs,
// and a command sequencer executing bursts against an internal 32-bit word memory.

module mcb_port_responder_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [W-1:0]                   din,
    input  logic                           pop,
    output logic [W-1:0]                   dout,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Push is refused only on a full FIFO, so push+pop at full drops the push.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end
endmodule

module mcb_port_responder #(
    parameter int MEM_ADDR_BITS = 10,
    parameter int CALIB_CYCLES  = 16,
    parameter int CMD_DEPTH     = 4,
    parameter int DATA_DEPTH    = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        calib_done,
    input  logic        p0_cmd_en,
    input  logic [2:0]  p0_cmd_instr,
    input  logic [29:0] p0_cmd_byte_addr,
    input  logic [5:0]  p0_cmd_bl,
    output logic        p0_cmd_full,
    input  logic        p0_wr_en,
    input  logic [31:0] p0_wr_data,
    input  logic [3:0]  p0_wr_mask,
    output logic        p0_wr_full,
    input  logic        p0_rd_en,
    output logic [31:0] p0_rd_data,
    output logic        p0_rd_empty,
    output logic [2:0]  err_flags,
    output logic [1:0]  fsm_state
);
    localparam int CMD_W = 2 + MEM_ADDR_BITS + 6;
    localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
    localparam int CCW   = $clog2(CMD_DEPTH + 1);
    localparam int DCW   = $clog2(DATA_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

    state_t                   state, state_next;
    logic [CAL_W-1:0]         calib_cnt;
    logic [MEM_ADDR_BITS-1:0] cur_addr;
    logic [5:0]               cur_bl;
    logic [5:0]               beat;
    logic                     in_flight;
    logic [31:0]              rd_word;
    logic [31:0]              mem [1 << MEM_ADDR_BITS];
    logic [MEM_ADDR_BITS-1:0] mem_addr;

    logic [CMD_W-1:0] cmd_head;
    logic [CCW-1:0]   cmd_count;
    logic             cmd_full, cmd_empty, cmd_pop;
    logic [35:0]      wr_head;
    logic [DCW-1:0]   wr_count;
    logic             wr_fifo_full, wr_empty, wr_pop;
    logic [31:0]      rd_head;
    logic [DCW-1:0]   rd_count;
    logic             rd_full, rd_empty;
    logic             mem_we, rd_issue, rd_room;
    logic             cmd_nop, cmd_rd;
    logic [MEM_ADDR_BITS-1:0] cmd_addr;
    logic [5:0]       cmd_bl;
    logic             unused_bits;

    assign unused_bits = ^{p0_cmd_instr[1], p0_cmd_byte_addr[29:MEM_ADDR_BITS+2],
                           p0_cmd_byte_addr[1:0], cmd_count, wr_count, rd_full};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            calib_cnt  <= '0;
            calib_done <= 1'b0;
        end else if (!calib_done) begin
            calib_cnt <= calib_cnt + CAL_W'(1);
            if (calib_cnt == CAL_W'(CALIB_CYCLES - 1)) calib_done <= 1'b1;
        end
    end

    // Until calibration completes both input FIFOs look full and every enable is inert.
    assign p0_cmd_full = !calib_done || cmd_full;
    assign p0_wr_full  = !calib_done || wr_fifo_full;
    assign p0_rd_empty = rd_empty;
    assign p0_rd_data  = rd_empty ? 32'd0 : rd_head;

    mcb_port_responder_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(clk), .rst_n(reset_n),
        .push(p0_cmd_en && calib_done),
        .din({p0_cmd_instr[2], p0_cmd_instr[0], p0_cmd_byte_addr[MEM_ADDR_BITS+1:2], p0_cmd_bl}),
        .pop(cmd_pop), .dout(cmd_head), .count(cmd_count), .full(cmd_full), .empty(cmd_empty)
    );

    mcb_port_responder_fifo #(.W(36), .DEPTH(DATA_DEPTH)) u_wr_fifo (
        .clk(clk), .rst_n(reset_n),
        .push(p0_wr_en && calib_done), .din({p0_wr_data, p0_wr_mask}),
        .pop(wr_pop), .dout(wr_head), .count(wr_count), .full(wr_fifo_full), .empty(wr_empty)
    );

    mcb_port_responder_fifo #(.W(32), .DEPTH(DATA_DEPTH)) u_rd_fifo (
        .clk(clk), .rst_n(reset_n),
        .push(in_flight), .din(rd_word),
        .pop(p0_rd_en), .dout(rd_head), .count(rd_count), .full(rd_full), .empty(rd_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_flags <= 3'b000;
        else begin
            if (calib_done && p0_rd_en && rd_empty)     err_flags[2] <= 1'b1;
            if (calib_done && p0_wr_en && wr_fifo_full) err_flags[1] <= 1'b1;
            if (calib_done && p0_cmd_en && cmd_full)    err_flags[0] <= 1'b1;
        end
    end

    assign cmd_nop  = cmd_head[CMD_W-1];
    assign cmd_rd   = cmd_head[CMD_W-2];
    assign cmd_addr = cmd_head[6 +: MEM_ADDR_BITS];
    assign cmd_bl   = cmd_head[5:0];

    // The word still in flight is counted so a read is never issued without a free slot.
    assign rd_room  = (32'(rd_count) + 32'(in_flight)) < 32'(DATA_DEPTH);
    assign mem_addr = cur_addr + MEM_ADDR_BITS'(beat);
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        cmd_pop    = 1'b0;
        wr_pop     = 1'b0;
        mem_we     = 1'b0;
        rd_issue   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop = 1'b1;
                    if (cmd_nop)     state_next = S_IDLE;
                    else if (cmd_rd) state_next = S_READ;
                    else             state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!wr_empty) begin
                    wr_pop = 1'b1;
                    mem_we = 1'b1;
                    if (beat == cur_bl) state_next = S_IDLE;
                end
            end
            S_READ: begin
                if (rd_room) begin
                    rd_issue = 1'b1;
                    if (beat == cur_bl) state_next = S_DRAIN;
                end
            end
            S_DRAIN: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            cur_bl    <= '0;
            beat      <= '0;
            in_flight <= 1'b0;
        end else begin
            state     <= state_next;
            in_flight <= rd_issue;
            if (cmd_pop) begin
                cur_addr <= cmd_addr;
                cur_bl   <= cmd_bl;
                beat     <= '0;
            end else if (mem_we || rd_issue) begin
                beat <= beat + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (!wr_head[i]) mem[mem_addr][8*i +: 8] <= wr_head[4 + 8*i +: 8];
            end
        end
        if (rd_issue) rd_word <= mem[mem_addr];
    end
endmodule
